debug_trace_database: RTL
=========================

Name: debug_trace_database

Overview:
Parametrised successor to the debug-unit snapshot database.
- Captures a multi-word snapshot of pipeline state each valid cycle into a circular trace buffer of PROFUNDIDAD entries.
- Freezes the buffer a programmable number of cycles after halt is detected.
- Serves random-access word reads to the debug unit / UART transmitter.
- Sits between the MIPS pipeline latches and the debug unit.

Parameters:
CANT_CANALES, 16, 32-bit words per snapshot (channels)
PROFUNDIDAD, 8, snapshots held; power of two, >= 2
POST_TRIGGER, 2, valid captures accepted after the halt snapshot before freezing (0..PROFUNDIDAD-1)
LONGITUD_DATO, 32, width of each channel word and of o_dato

Ports:
i_clock  in  1  system clock; all state updates on rising edge
i_soft_reset  in  1  reset, asynchronous, active-low (0 = reset)
i_snapshot  in  CANT_CANALES*LONGITUD_DATO  flattened snapshot; channel k at bits [k*32 +: 32]
i_capture_valid  in  1  snapshot valid this cycle (pipeline advanced)
i_halt_detected  in  1  halt reached write-back; sampled only with i_capture_valid
i_arm  in  1  one-cycle pulse: clear buffer, start capturing
i_clear  in  1  one-cycle pulse: clear buffer, go idle
i_rd_req  in  1  read request
i_rd_snap  in  clogb2(PROFUNDIDAD)  snapshot index, 0 = oldest held
i_rd_word  in  clogb2(CANT_CANALES)  channel index
o_dato  out  LONGITUD_DATO  read data
o_dato_valid  out  1  one-cycle pulse; o_dato valid
o_rd_error  out  1  pulses with o_dato_valid when the request was out of range
o_count  out  clogb2(PROFUNDIDAD)  snapshots held, saturates at PROFUNDIDAD
o_wrapped  out  1  buffer has overwritten at least one entry
o_frozen  out  1  state == ST_CONGELADO

Behaviour:
Reset (asynchronous, active-low):
- State ST_IDLE; all outputs 0; write pointer and post counter 0.
- Trace memory contents are not reset.

States:
- ST_IDLE: no captures.
  - i_arm -> ST_CAPTURA.
- ST_CAPTURA: each i_capture_valid writes i_snapshot at wr_ptr.
  - wr_ptr increments mod PROFUNDIDAD; o_count increments, saturating.
  - o_wrapped sets on the first write once o_count == PROFUNDIDAD.
  - Valid capture with i_halt_detected=1: the snapshot is written, post counter loads POST_TRIGGER, next state is ST_POST. If POST_TRIGGER==0, next state is ST_CONGELADO.
- ST_POST: each valid capture is written and the counter decrements.
  - The write that reaches 0 moves to ST_CONGELADO.
  - i_halt_detected is ignored in this state.
- ST_CONGELADO: no writes; buffer is readable.
  - i_arm -> ST_CAPTURA.

Global controls:
- i_arm in any state: wr_ptr=0, o_count=0, o_wrapped=0, post counter=0, next ST_CAPTURA. No capture occurs in the arm cycle.
- i_clear in any state: same clearing, next ST_IDLE. i_clear has priority over i_arm.

Reads (allowed in every state):
- One-cycle latency: o_dato and o_dato_valid are registered on the edge after i_rd_req=1.
- Physical slot = (base + i_rd_snap) mod PROFUNDIDAD, where base = o_wrapped ? wr_ptr : 0.
- i_rd_snap >= o_count or i_rd_word >= CANT_CANALES: o_dato=0, o_rd_error=1.
- o_dato holds its last value when no request is made.
- Read and write to the same slot in the same cycle return the old contents (read-before-write). base is evaluated with pre-edge pointer values.
- Back-to-back requests give one result per cycle.

Optional Feature:
Macro DEBUG_TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter (reset 0, wraps) is stored with every snapshot.
  - It is readable at i_rd_word == CANT_CANALES; i_rd_word width becomes clogb2(CANT_CANALES+1).
  - Only indices > CANT_CANALES flag o_rd_error.
- Undefined: no counter and no extra storage; i_rd_word == CANT_CANALES is an error.

Decomposition:
- Package debug_trace_pkg holds:
  - clogb2 function;
  - state encoding constants ST_IDLE=0, ST_CAPTURA=1, ST_POST=2, ST_CONGELADO=3;
  - LONGITUD_DATO default.
- Sub-module trace_ram: simple dual-port memory of PROFUNDIDAD x (CANT_CANALES[+1])*LONGITUD_DATO.
  - One write port; one synchronous, read-before-write word-select read port.
- The FSM, pointers and range checks stay in debug_trace_database.

Test Plan:
- Reset low mid-capture (o_count=3) -> all outputs 0, o_frozen=0, state idle immediately (asynchronous).
- Arm, 3 valid captures with channel0 = 0xA0,0xA1,0xA2; read snap 1 word 0 -> next cycle o_dato=0xA1, o_dato_valid=1, o_count=3.
- Arm, 11 captures (values 1..11) with PROFUNDIDAD=8 -> o_wrapped=1, o_count=8; read snap 0 -> 4; read snap 7 -> 11.
- Arm, halt on capture value 5, POST_TRIGGER=2, then 4 more captures -> o_frozen=1 after value 7; read snap (o_count-1) -> 7; values 8,9 not stored.
- Read snap 5 with o_count=3, and read word 16 with CANT_CANALES=16 (macro off) -> o_dato=0, o_rd_error=1.
- Same-cycle i_arm and i_clear while frozen -> ST_IDLE, o_count=0, o_frozen=0; a later i_capture_valid is not stored.

Source files
------------

// File: rtl/debug_trace_database_pkg.sv
// debug_trace_pkg: shared definitions for the debug trace database.
//   - clogb2(): number of bits needed to hold the value itself (clogb2(8)=4),
//     used for counters that must represent the full depth.
//   - estado_t: capture FSM state encoding.
//   - LONGITUD_DATO_DEFAULT: default channel word width.
package debug_trace_pkg;

    localparam int LONGITUD_DATO_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAPTURA   = 2'd1,
        ST_POST      = 2'd2,
        ST_CONGELADO = 2'd3
    } estado_t;

    function automatic int clogb2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                bits = bits + 1;
                rem  = rem >> 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/debug_trace_database_if.sv
// debug_trace_database_if: random-access read bus between the debug unit
// (master) and the trace database (slave).
//   i_rd_req      request strobe
//   i_rd_snap     snapshot index, 0 = oldest held
//   i_rd_word     channel index
//   o_dato        read data, valid one cycle after the request
//   o_dato_valid  one-cycle pulse marking o_dato
//   o_rd_error    pulses with o_dato_valid for an out-of-range request
interface debug_trace_database_if #(
    parameter int SNAP_W = 4,
    parameter int WORD_W = 5,
    parameter int DATA_W = 32
);
    logic              i_rd_req;
    logic [SNAP_W-1:0] i_rd_snap;
    logic [WORD_W-1:0] i_rd_word;
    logic [DATA_W-1:0] o_dato;
    logic              o_dato_valid;
    logic              o_rd_error;

    modport master (
        output i_rd_req, i_rd_snap, i_rd_word,
        input  o_dato, o_dato_valid, o_rd_error
    );

    modport slave (
        input  i_rd_req, i_rd_snap, i_rd_word,
        output o_dato, o_dato_valid, o_rd_error
    );
endinterface

// File: rtl/debug_trace_database_trace_ram.sv
// trace_ram: DEPTH rows of NUM_WORDS*DATA_W bits.
//   Write port: whole row written at wr_addr when wr_en.
//   Read port : synchronous, word-selected; rd_data updates only when rd_en
//               and otherwise holds. A read of the row being written in the
//               same cycle returns the old contents.
// Ports: clk, rst_n (async, active-low, clears only the read register),
//        wr_en/wr_addr/wr_row, rd_en/rd_addr/rd_word, rd_data.
module trace_ram #(
    parameter int DEPTH     = 8,
    parameter int NUM_WORDS = 16,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 3,
    parameter int WORD_W    = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [NUM_WORDS*DATA_W-1:0] wr_row,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    input  logic [WORD_W-1:0]           rd_word,
    output logic [DATA_W-1:0]           rd_data
);

    logic [NUM_WORDS*DATA_W-1:0] mem [DEPTH];
    logic [NUM_WORDS*DATA_W-1:0] rd_row;
    logic [DATA_W-1:0]           word_sel;
    logic [DATA_W-1:0]           rd_data_d;
    logic [DATA_W-1:0]           rd_data_q;

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_row;
        end
    end

    // Word mux over the addressed row; an index past the row selects zero,
    // though the parent never enables a read for such an index.
    always_comb begin
        rd_row   = mem[rd_addr];
        word_sel = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (rd_word == WORD_W'(k)) begin
                word_sel = rd_row[k*DATA_W +: DATA_W];
            end
        end
        rd_data_d = rd_en ? word_sel : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/debug_trace_database.sv
// debug_trace_database: circular trace buffer of pipeline snapshots for the
// debug unit. Captures one snapshot per valid cycle while armed, freezes
// POST_TRIGGER valid captures after the halt snapshot, and serves one-cycle
// latency word reads indexed from the oldest held snapshot.
// Ports:
//   i_clock, i_soft_reset (async, active-low)
//   i_snapshot, i_capture_valid, i_halt_detected  pipeline side
//   i_arm, i_clear                                 control pulses
//   rd_bus (debug_trace_database_if.slave)         read request/response
//   o_count, o_wrapped, o_frozen                   buffer status
// Optional: define DEBUG_TRACE_TIMESTAMP_EN to store a free-running 32-bit
// cycle counter with each snapshot, readable at word index CANT_CANALES.
module debug_trace_database
    import debug_trace_pkg::*;
#(
    parameter int CANT_CANALES  = 16,
    parameter int PROFUNDIDAD   = 8,
    parameter int POST_TRIGGER  = 2,
    parameter int LONGITUD_DATO = LONGITUD_DATO_DEFAULT
) (
    input  logic                                  i_clock,
    input  logic                                  i_soft_reset,
    input  logic [CANT_CANALES*LONGITUD_DATO-1:0] i_snapshot,
    input  logic                                  i_capture_valid,
    input  logic                                  i_halt_detected,
    input  logic                                  i_arm,
    input  logic                                  i_clear,
    debug_trace_database_if.slave                 rd_bus,
    output logic [clogb2(PROFUNDIDAD)-1:0]        o_count,
    output logic                                  o_wrapped,
    output logic                                  o_frozen
);

    localparam int CNT_W = clogb2(PROFUNDIDAD);
    localparam int PTR_W = clogb2(PROFUNDIDAD - 1);
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    localparam int NUM_WORDS = CANT_CANALES + 1;
`else
    localparam int NUM_WORDS = CANT_CANALES;
`endif
    localparam int WORD_W = clogb2(NUM_WORDS);
    localparam int ROW_W  = NUM_WORDS * LONGITUD_DATO;

    estado_t          state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             frozen_q, frozen_d;
    logic [PTR_W-1:0] post_q, post_d;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;

    logic [PTR_W-1:0] rd_base;
    logic [PTR_W-1:0] rd_slot;
    logic             range_err;
    logic             ram_rd_en;
    logic             dato_valid_q, dato_valid_d;
    logic             rd_error_q, rd_error_d;
    logic             zero_q, zero_d;
    logic [LONGITUD_DATO-1:0] ram_dout;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;

    assign ts_d   = ts_q + 32'd1;
    assign wr_row = {LONGITUD_DATO'(ts_q), i_snapshot};

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end
`else
    assign wr_row = i_snapshot;
`endif

    // Capture FSM next state. Clear beats arm; neither writes in its own
    // cycle. CAPTURA and POST share the write/pointer bookkeeping, then
    // differ only in how they leave.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        post_d    = post_q;
        wr_en     = 1'b0;

        if (i_clear || i_arm) begin
            state_d   = i_clear ? ST_IDLE : ST_CAPTURA;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            post_d    = '0;
        end else if ((state_q == ST_CAPTURA || state_q == ST_POST) && i_capture_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q == CNT_W'(PROFUNDIDAD)) begin
                wrapped_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end

            if (state_q == ST_CAPTURA) begin
                if (i_halt_detected) begin
                    post_d  = PTR_W'(POST_TRIGGER);
                    state_d = (POST_TRIGGER == 0) ? ST_CONGELADO : ST_POST;
                end
            end else begin
                post_d = post_q - PTR_W'(1);
                if (post_q == PTR_W'(1)) begin
                    state_d = ST_CONGELADO;
                end
            end
        end

        frozen_d = (state_d == ST_CONGELADO);
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            frozen_q  <= 1'b0;
            post_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            frozen_q  <= frozen_d;
            post_q    <= post_d;
        end
    end

    // Once wrapped, the write pointer marks the oldest entry. The RAM is only
    // read for in-range requests; zero_q remembers whether the last answer was
    // an error so o_dato reads zero and keeps holding it between requests.
    always_comb begin
        rd_base      = wrapped_q ? wr_ptr_q : '0;
        rd_slot      = rd_base + rd_bus.i_rd_snap[PTR_W-1:0];
        range_err    = (rd_bus.i_rd_snap >= count_q) ||
                       (rd_bus.i_rd_word >= WORD_W'(NUM_WORDS));
        ram_rd_en    = rd_bus.i_rd_req && !range_err;
        dato_valid_d = rd_bus.i_rd_req;
        rd_error_d   = rd_bus.i_rd_req && range_err;
        zero_d       = rd_bus.i_rd_req ? range_err : zero_q;
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            dato_valid_q <= 1'b0;
            rd_error_q   <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            dato_valid_q <= dato_valid_d;
            rd_error_q   <= rd_error_d;
            zero_q       <= zero_d;
        end
    end

    trace_ram #(
        .DEPTH     (PROFUNDIDAD),
        .NUM_WORDS (NUM_WORDS),
        .DATA_W    (LONGITUD_DATO),
        .ADDR_W    (PTR_W),
        .WORD_W    (WORD_W)
    ) u_trace_ram (
        .clk     (i_clock),
        .rst_n   (i_soft_reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_row  (wr_row),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_slot),
        .rd_word (rd_bus.i_rd_word),
        .rd_data (ram_dout)
    );

    assign rd_bus.o_dato       = zero_q ? '0 : ram_dout;
    assign rd_bus.o_dato_valid = dato_valid_q;
    assign rd_bus.o_rd_error   = rd_error_q;
    assign o_count             = count_q;
    assign o_wrapped           = wrapped_q;
    assign o_frozen            = frozen_q;

endmodule
